// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory port between the icache and
// the dcache. Each grant runs IDLE -> BUSY_x -> RESP_x -> IDLE and ends with
// one ack pulse. With MEM_ARB_ROUND_ROBIN_EN defined, ties alternate between
// the two requesters. Without it, dcache always wins a tie.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_we,
   input  logic [DATA_W-1:0] d_wd,
   output logic              d_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   input  logic              mem_ready
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      RESP_I = 3'd3,
      RESP_D = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              grant_i, grant_d;
   logic              d_wins;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_we_q;
   logic [DATA_W-1:0] mem_wd_q;
   logic [DATA_W-1:0] rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // last_grant_q: 0 = icache was granted last, 1 = dcache was granted last
   logic last_grant_q;

   // dcache wins when alone, or on a tie when icache was granted last
   assign d_wins = d_req & (~i_req | ~last_grant_q);

   // Remember the most recent winner, tied or not
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        last_grant_q <= 1'b0;
      else if (grant_d) last_grant_q <= 1'b1;
      else if (grant_i) last_grant_q <= 1'b0;
   end
`else
   // Fixed priority: dcache wins every tie
   assign d_wins = d_req;
`endif

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and grant decode. Requests are only evaluated in IDLE.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (d_wins) begin
               grant_d = 1'b1;
               state_d = BUSY_D;
            end else if (i_req) begin
               grant_i = 1'b1;
               state_d = BUSY_I;
            end
         end
         BUSY_I:  if (mem_ready) state_d = RESP_I;
         BUSY_D:  if (mem_ready) state_d = RESP_D;
         RESP_I:  state_d = IDLE;
         RESP_D:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State-decoded outputs. They follow state_q, so reset clears them at once.
   always_comb begin
      i_ack   = (state_q == RESP_I);
      d_ack   = (state_q == RESP_D);
      mem_req = (state_q == BUSY_I) || (state_q == BUSY_D);
      busy    = (state_q != IDLE);
   end

   // Latch the winner's request on grant and capture read data on completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr_q <= '0;
         mem_we_q   <= 1'b0;
         mem_wd_q   <= '0;
         rdata_q    <= '0;
      end else begin
         if (grant_d) begin
            mem_addr_q <= d_addr;
            mem_we_q   <= d_we;
            mem_wd_q   <= d_wd;
         end else if (grant_i) begin
            mem_addr_q <= i_addr;
            mem_we_q   <= 1'b0;
            mem_wd_q   <= '0;
         end
         // mem_ready is ignored unless a request is outstanding
         if (mem_req && mem_ready) begin
            rdata_q  <= mem_rd;
            mem_we_q <= 1'b0;
         end
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_we   = mem_we_q;
   assign mem_wd   = mem_wd_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Inputs change 1 ns after a
// rising edge and outputs are checked at the same point. The tie-break
// expectations follow MEM_ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_req = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic              i_ack;
   logic              d_req = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic              d_we = 1'b0;
   logic [DATA_W-1:0] d_wd = '0;
   logic              d_ack;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] mem_rd = '0;
   logic              mem_ready = 1'b0;

   int tests = 0;
   int fails = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_we      (d_we),
      .d_wd      (d_wd),
      .d_ack     (d_ack),
      .rdata     (rdata),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic exp_is_d [4];

   initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_is_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif

      // ---- Reset values ----
      #2;
      check_bit ("rst_mem_req",  mem_req, 1'b0);
      check_bit ("rst_busy",     busy,    1'b0);
      check_bit ("rst_i_ack",    i_ack,   1'b0);
      check_bit ("rst_d_ack",    d_ack,   1'b0);
      check_bit ("rst_mem_we",   mem_we,  1'b0);
      check_word("rst_mem_addr", mem_addr, 32'h0);
      check_word("rst_mem_wd",   mem_wd,   32'h0);
      check_word("rst_rdata",    rdata,    32'h0);
      step();
      reset = 1'b0;

      // ---- icache read, zero-wait memory ----
      i_req = 1'b1; i_addr = 32'h40;                   // cycle 0
      check_bit("t1_c0_mem_req", mem_req, 1'b0);
      step();                                          // cycle 1
      check_bit ("t1_c1_mem_req",  mem_req, 1'b1);
      check_word("t1_c1_mem_addr", mem_addr, 32'h40);
      check_bit ("t1_c1_mem_we",   mem_we,  1'b0);
      check_bit ("t1_c1_busy",     busy,    1'b1);
      mem_ready = 1'b1; mem_rd = 32'h8C02_0000;
      step();                                          // cycle 2
      check_bit ("t1_c2_i_ack",   i_ack,   1'b1);
      check_bit ("t1_c2_d_ack",   d_ack,   1'b0);
      check_word("t1_c2_rdata",   rdata,   32'h8C02_0000);
      check_bit ("t1_c2_mem_req", mem_req, 1'b0);
      mem_ready = 1'b0; i_req = 1'b0;
      step();                                          // cycle 3
      check_bit("t1_c3_i_ack", i_ack, 1'b0);
      check_bit("t1_c3_busy",  busy,  1'b0);

      // ---- dcache write, mem_ready in cycle 3 ----
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wd = 32'h7;   // cycle 0
      for (int c = 1; c <= 3; c++) begin
         step();                                       // cycles 1..3
         check_bit ($sformatf("t2_c%0d_mem_req", c),  mem_req, 1'b1);
         check_word($sformatf("t2_c%0d_mem_addr", c), mem_addr, 32'h54);
         check_bit ($sformatf("t2_c%0d_mem_we", c),   mem_we,  1'b1);
         check_word($sformatf("t2_c%0d_mem_wd", c),   mem_wd,  32'h7);
         check_bit ($sformatf("t2_c%0d_d_ack", c),    d_ack,   1'b0);
      end
      mem_ready = 1'b1; mem_rd = 32'h0000_1234;
      step();                                          // cycle 4
      check_bit ("t2_c4_d_ack",   d_ack,   1'b1);
      check_bit ("t2_c4_mem_we",  mem_we,  1'b0);
      check_bit ("t2_c4_mem_req", mem_req, 1'b0);
      check_word("t2_c4_rdata",   rdata,   32'h0000_1234);
      mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
      step();                                          // cycle 5
      check_bit("t2_c5_d_ack", d_ack, 1'b0);

      // ---- Tie break from a fresh reset (last_grant = icache) ----
      reset = 1'b1;
      step();
      reset = 1'b0;
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();                                       // BUSY
         check_word($sformatf("tie%0d_mem_addr", n), mem_addr, exp_is_d[n] ? 32'h200 : 32'h100);
         mem_ready = 1'b1; mem_rd = 32'h1000 + 32'(n);
         step();                                       // RESP
         mem_ready = 1'b0;
         check_bit ($sformatf("tie%0d_d_ack", n), d_ack, exp_is_d[n]);
         check_bit ($sformatf("tie%0d_i_ack", n), i_ack, ~exp_is_d[n]);
         check_word($sformatf("tie%0d_rdata", n), rdata, 32'h1000 + 32'(n));
         if (n == 2) d_req = 1'b0;
         if (n == 3) i_req = 1'b0;
         step();                                       // IDLE
      end
      check_bit("tie_end_busy", busy, 1'b0);

      // ---- icache request arriving during BUSY_D ----
      d_req = 1'b1; d_addr = 32'h300;                  // cycle 0
      step();                                          // cycle 1
      i_req = 1'b1; i_addr = 32'h44;
      check_word("t4_c1_mem_addr", mem_addr, 32'h300);
      for (int c = 2; c <= 5; c++) begin
         step();                                       // cycles 2..5
         check_word($sformatf("t4_c%0d_mem_addr", c), mem_addr, 32'h300);
         check_bit ($sformatf("t4_c%0d_i_ack", c),    i_ack,    1'b0);
      end
      mem_ready = 1'b1; mem_rd = 32'h5555_AAAA;
      step();                                          // cycle 6
      check_bit("t4_c6_d_ack", d_ack, 1'b1);
      check_bit("t4_c6_i_ack", i_ack, 1'b0);
      mem_ready = 1'b0; d_req = 1'b0;
      step();                                          // cycle 7
      check_bit("t4_c7_mem_req", mem_req, 1'b0);
      step();                                          // cycle 8
      check_bit ("t4_c8_mem_req",  mem_req,  1'b1);
      check_word("t4_c8_mem_addr", mem_addr, 32'h44);
      mem_ready = 1'b1; mem_rd = 32'h0BAD_BEEF;
      step();                                          // cycle 9
      check_bit ("t4_c9_i_ack", i_ack, 1'b1);
      check_word("t4_c9_rdata", rdata, 32'h0BAD_BEEF);
      mem_ready = 1'b0; i_req = 1'b0;
      step();

      // ---- Asynchronous reset in the middle of BUSY_I ----
      i_req = 1'b1; i_addr = 32'h80;
      step();                                          // BUSY_I
      check_bit("t5_busy_mem_req", mem_req, 1'b1);
      #3;
      reset = 1'b1;
      #1;
      check_bit("t5_async_mem_req", mem_req, 1'b0);
      check_bit("t5_async_busy",    busy,    1'b0);
      check_bit("t5_async_i_ack",   i_ack,   1'b0);
      check_bit("t5_async_d_ack",   d_ack,   1'b0);
      i_req = 1'b0; mem_ready = 1'b1;
      step();
      reset = 1'b0; mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check_bit($sformatf("t5_post%0d_i_ack", c), i_ack, 1'b0);
         check_bit($sformatf("t5_post%0d_busy", c),  busy,  1'b0);
      end
      i_req = 1'b1; i_addr = 32'h88;
      step();
      check_bit ("t5_new_mem_req",  mem_req,  1'b1);
      check_word("t5_new_mem_addr", mem_addr, 32'h88);
      mem_ready = 1'b1; mem_rd = 32'hCAFE_F00D;
      step();
      check_bit ("t5_new_i_ack", i_ack, 1'b1);
      check_word("t5_new_rdata", rdata, 32'hCAFE_F00D);
      mem_ready = 1'b0; i_req = 1'b0;
      step();

      // ---- Spurious mem_ready in IDLE ----
      mem_ready = 1'b1; mem_rd = 32'hDEAD_DEAD;
      step();
      step();
      check_bit ("t6_busy",    busy,    1'b0);
      check_bit ("t6_mem_req", mem_req, 1'b0);
      check_bit ("t6_i_ack",   i_ack,   1'b0);
      check_bit ("t6_d_ack",   d_ack,   1'b0);
      check_word("t6_rdata",   rdata,   32'hCAFE_F00D);
      mem_ready = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
